// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default geometry, clear-FSM state
// encoding and the LED bit map (LED k shows entry k+1, two bits per entry).
// Optional feature macro: REGFILE_BYPASS_EN (write-first read bypass).
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_LED_REGS = 3;

  // LED k mirrors entry (k + LED_FIRST_ENTRY), LED_BITS_PER_REG low bits
  localparam int LED_BITS_PER_REG = 2;
  localparam int LED_FIRST_ENTRY  = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Array index width; a single-entry file still needs one index bit
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks clr_addr from 0 to DEPTH-1, one entry per cycle,
// after reset or on a clear_req pulse. busy/clr_we are high while walking.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        r_state;
  clr_state_e        w_state_next;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_next;

  // State and index registers; reset (also mid-clear) restarts the walk at 0
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_idx <= w_clr_idx_next;
    end
  end

  // Next-state logic; clear_req is only honoured from IDLE
  always_comb begin
    w_state_next   = r_state;
    w_clr_idx_next = r_clr_idx;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_next   = ST_CLEAR;
          w_clr_idx_next = '0;
        end
      end
      ST_CLEAR: begin
        if (r_clr_idx == LAST_IDX) begin
          w_state_next   = ST_IDLE;
          w_clr_idx_next = '0;
        end else begin
          w_clr_idx_next = r_clr_idx + 1'b1;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_clr_idx_next = '0;
      end
    endcase
  end

  assign busy     = (r_state == ST_CLEAR);
  assign clr_we   = (r_state == ST_CLEAR);
  assign clr_addr = r_clr_idx;

endmodule

// File: rtl/regfile_param.sv
// MIPS-style register file: two registered read ports, one write port,
// optional hardwired r0, self-clearing storage and an LED mirror of the low
// bits of entries 1..LED_REGS.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined a legal write to
// the address being read is forwarded to that read port in the same cycle.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int LED_REGS = DEF_LED_REGS
) (
  input  logic                               clock_in,
  input  logic                               reset_n,
  input  logic                               reg_write,
  input  logic [ADDR_W-1:0]                  write_reg,
  input  logic [DATA_W-1:0]                  write_data,
  input  logic [ADDR_W-1:0]                  read_reg1,
  input  logic [ADDR_W-1:0]                  read_reg2,
  output logic [DATA_W-1:0]                  read_data1,
  output logic [DATA_W-1:0]                  read_data2,
  input  logic                               clear_req,
  output logic                               busy,
  output logic [LED_BITS_PER_REG*LED_REGS-1:0] led
);

  localparam int              IDX_W   = idx_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam int              LED_W   = LED_BITS_PER_REG * LED_REGS;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_user_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [LED_W-1:0]  w_led_next;
  logic [LED_W-1:0]  r_led;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_fsm (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .busy      (w_busy),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr)
  );

  // A user write lands only when idle, in range and not aimed at a hardwired r0
  assign w_user_we = reg_write && !w_busy
                   && ({1'b0, write_reg} < DEPTH_C)
                   && !((ZERO_REG != 0) && (write_reg == '0));

  // Clear sequencer owns the write port while it runs
  assign w_we    = w_clr_we || w_user_we;
  assign w_waddr = w_clr_we ? w_clr_addr : write_reg;
  assign w_wdata = w_clr_we ? '0 : write_data;

  // Storage write port (no reset so the array can map to RAM)
  always_ff @(posedge clock_in) begin
    if (w_we) begin
      r_mem[w_waddr[IDX_W-1:0]] <= w_wdata;
    end
  end

  assign w_rd_addr[0] = read_reg1;
  assign w_rd_addr[1] = read_reg2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic              w_hit;
      logic              w_byp;
      logic [DATA_W-1:0] r_data;

      assign w_hit = ({1'b0, w_rd_addr[gi]} < DEPTH_C)
                   && !((ZERO_REG != 0) && (w_rd_addr[gi] == '0));
`ifdef REGFILE_BYPASS_EN
      assign w_byp = w_user_we && (write_reg == w_rd_addr[gi]);
`else
      assign w_byp = 1'b0;
`endif

      // Registered read: zero while clearing, forwarded data on bypass hit
      always_ff @(posedge clock_in) begin
        if (!reset_n) begin
          r_data <= '0;
        end else if (w_busy) begin
          r_data <= '0;
        end else if (w_byp) begin
          r_data <= write_data;
        end else if (w_hit) begin
          r_data <= r_mem[w_rd_addr[gi][IDX_W-1:0]];
        end else begin
          r_data <= '0;
        end
      end
    end

    for (gi = 0; gi < LED_REGS; gi++) begin : g_led
      if (gi + LED_FIRST_ENTRY < DEPTH) begin : g_impl
        assign w_led_next[gi*LED_BITS_PER_REG +: LED_BITS_PER_REG] =
          r_mem[gi + LED_FIRST_ENTRY][LED_BITS_PER_REG-1:0];
      end else begin : g_unimpl
        assign w_led_next[gi*LED_BITS_PER_REG +: LED_BITS_PER_REG] = '0;
      end
    end
  endgenerate

  // LED mirror refreshes every cycle from stored contents, dark while clearing
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_led <= '0;
    end else if (w_busy) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign read_data1 = g_rd[0].r_data;
  assign read_data2 = g_rd[1].r_data;
  assign busy       = w_busy;
  assign led        = r_led;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param (DEPTH=8, ZERO_REG=1, LED_REGS=3).
// Stimulus pushes the expected outputs for each clock edge into a queue; a
// monitor on the falling edge pops and compares. Honours REGFILE_BYPASS_EN.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [AW-1:0] read_reg1;
  logic [AW-1:0] read_reg2;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic          clear_req;
  logic          busy;
  logic [5:0]    led;

  regfile_param #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .ZERO_REG (1),
    .LED_REGS (3)
  ) dut (
    .clock_in   (clk),
    .reset_n    (reset_n),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .clear_req  (clear_req),
    .busy       (busy),
    .led        (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [5:0]  led;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every expectation due at the current edge count
  always @(negedge clk) begin
    exp_t item;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item = sb.pop_front();
      if (item.cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: stale expectation cyc %0d at cyc %0d", item.name, item.cyc, cyc);
      end else begin
        check({item.name, ".rd1"}, read_data1, item.rd1);
        check({item.name, ".rd2"}, read_data2, item.rd2);
        check({item.name, ".led"}, {26'd0, led}, {26'd0, item.led});
        check({item.name, ".busy"}, {31'd0, busy}, {31'd0, item.busy});
        $display("[TB] cyc %0d %s rd1=0x%0h rd2=0x%0h led=%b busy=%0b",
                 cyc, item.name, read_data1, read_data2, led, busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after the edge just taken
  task automatic expect_out(input string name, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [5:0] el, input logic eb);
    exp_t item;
    item.cyc  = cyc;
    item.name = name;
    item.rd1  = e1;
    item.rd2  = e2;
    item.led  = el;
    item.busy = eb;
    sb.push_back(item);
  endtask

  task automatic set_wr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_write  = we;
    write_reg  = a;
    write_data = d;
  endtask

  task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    read_reg1 = a1;
    read_reg2 = a2;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_req = 1'b0;
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd3, 5'd4);

    // 1: reset, then busy for exactly DEPTH cycles; writes during busy dropped
    step();
    expect_out("reset", 0, 0, 6'h00, 1'b1);
    reset_n = 1'b1;
    set_wr(1'b1, 5'd2, 32'h0000FFFF);
    for (int i = 1; i < DEPTH; i++) begin
      step();
      expect_out($sformatf("initclr%0d", i), 0, 0, 6'h00, 1'b1);
    end
    step();
    expect_out("initclr_done", 0, 0, 6'h00, 1'b0);
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd2, 5'd2);
    step();
    expect_out("busy_write_dropped", 0, 0, 6'h00, 1'b0);

    // 2: write r5 then read on both ports
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    expect_out("wr_r5", 0, 0, 6'h00, 1'b0);
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd5, 5'd5);
    step();
    expect_out("rd_r5", 32'hDEADBEEF, 32'hDEADBEEF, 6'h00, 1'b0);

    // 3: r0 hardwired, r7 is the last entry, r12 is unimplemented
    set_wr(1'b1, 5'd0, 32'h1234);
    step();
    expect_out("wr_r0", 32'hDEADBEEF, 32'hDEADBEEF, 6'h00, 1'b0);
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd0, 5'd5);
    step();
    expect_out("rd_r0", 0, 32'hDEADBEEF, 6'h00, 1'b0);
    set_wr(1'b1, 5'd7, 32'h77);
    set_rd(5'd0, 5'd0);
    step();
    expect_out("wr_r7", 0, 0, 6'h00, 1'b0);
    set_wr(1'b1, 5'd12, 32'hCAFE);
    set_rd(5'd7, 5'd7);
    step();
    expect_out("rd_r7_wr_r12", 32'h77, 32'h77, 6'h00, 1'b0);
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(5'd12, 5'd7);
    step();
    expect_out("rd_r12", 0, 32'h77, 6'h00, 1'b0);

    // 4: same-cycle write/read of r3 (old value 0x11)
    set_wr(1'b1, 5'd3, 32'h11);
    step();
    expect_out("wr_r3_11", 0, 32'h77, 6'h00, 1'b0);
    set_wr(1'b1, 5'd3, 32'hA5);
    set_rd(5'd3, 5'd3);
    step();
    expect_out("bypass_r3", BYP ? 32'hA5 : 32'h11, BYP ? 32'hA5 : 32'h11, 6'h10, 1'b0);
    set_wr(1'b0, 5'd0, 32'd0);
    step();
    expect_out("rd_r3", 32'hA5, 32'hA5, 6'h10, 1'b0);

    // 5: LED map, then a requested clear (second request during clear ignored)
    set_wr(1'b1, 5'd1, 32'h3);
    step();
    expect_out("wr_r1", 32'hA5, 32'hA5, 6'h10, 1'b0);
    set_wr(1'b1, 5'd2, 32'h1);
    step();
    expect_out("wr_r2", 32'hA5, 32'hA5, 6'h13, 1'b0);
    set_wr(1'b1, 5'd3, 32'h2);
    set_rd(5'd1, 5'd2);
    step();
    expect_out("wr_r3_2", 32'h3, 32'h1, 6'h17, 1'b0);
    set_wr(1'b0, 5'd0, 32'd0);
    step();
    expect_out("led_100111", 32'h3, 32'h1, 6'b10_01_11, 1'b0);
    clear_req = 1'b1;
    step();
    expect_out("clr_start", 32'h3, 32'h1, 6'b10_01_11, 1'b1);
    clear_req = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      clear_req = (i == 3);
      step();
      expect_out($sformatf("clr%0d", i), 0, 0, 6'h00, 1'b1);
    end
    clear_req = 1'b0;
    step();
    expect_out("clr_done", 0, 0, 6'h00, 1'b0);
    set_rd(5'd1, 5'd5);
    step();
    expect_out("rd_after_clr", 0, 0, 6'h00, 1'b0);

    // 6: reset in the middle of a clear restarts the full walk
    set_wr(1'b1, 5'd1, 32'h3);
    set_rd(5'd1, 5'd1);
    step();
    expect_out("wr_r1_again", 0, 0, 6'h00, 1'b0);
    set_wr(1'b0, 5'd0, 32'd0);
    step();
    expect_out("rd_r1_again", 32'h3, 32'h3, 6'h03, 1'b0);
    clear_req = 1'b1;
    step();
    expect_out("clr2_start", 32'h3, 32'h3, 6'h03, 1'b1);
    clear_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_out($sformatf("clr2_%0d", i), 0, 0, 6'h00, 1'b1);
    end
    reset_n = 1'b0;
    step();
    expect_out("mid_reset", 0, 0, 6'h00, 1'b1);
    reset_n = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      step();
      expect_out($sformatf("reclr%0d", i), 0, 0, 6'h00, 1'b1);
    end
    step();
    expect_out("reclr_done", 0, 0, 6'h00, 1'b0);
    step();
    expect_out("rd_r1_final", 0, 0, 6'h00, 1'b0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
